program_sequencer: RTL and testbench

//   Instruction-fetch/sequencing front end that produces the 16-bit IR consumed by the

---
 rtl/seq_pkg.sv | 25 ++
 rtl/program_sequencer_next_pc.sv | 38 +++
 rtl/program_sequencer.sv | 93 +++++++++
 tb/tb_program_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the program sequencer: state encoding,
// the NOP instruction word and the IR bit positions of the PL/JB/BC controls.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } seqState_t;

   // op = 1100000: RW=0, MW=0, so the datapath writes nothing while it is shown
   localparam logic [15:0] NOP_IR = 16'hC000;

   localparam int PL_BIT_A = 15;
   localparam int PL_BIT_B = 14;
   localparam int JB_BIT   = 13;
   localparam int BC_BIT   = 9;

   localparam int OFF_W      = 6;
   localparam int OFF_HI_MSB = 8;
   localparam int OFF_HI_LSB = 6;
   localparam int OFF_LO_MSB = 2;
   localparam int OFF_LO_LSB = 0;

endpackage

// File: rtl/program_sequencer_next_pc.sv
// Combinational next-PC selection: increment, conditional relative branch on
// Z or N, or absolute jump to the register value on the A-bus.
module next_pc
   import seq_pkg::*;
#(
   parameter int PC_W = 8
) (
   input  logic [PC_W-1:0]  pc_i,
   input  logic             pl_i,
   input  logic             jb_i,
   input  logic             bc_i,
   input  logic [OFF_W-1:0] off_i,
   input  logic [PC_W-1:0]  reg_a_i,
   input  logic             z_i,
   input  logic             n_i,
   output logic [PC_W-1:0]  next_pc_o
);

   logic [PC_W-1:0] pcInc;
   logic [PC_W-1:0] pcBranch;
   logic            taken;

   // All PC arithmetic wraps modulo 2^PC_W; negative offsets wrap naturally
   assign pcInc    = pc_i + PC_W'(1);
   assign pcBranch = pc_i + {{(PC_W-OFF_W){off_i[OFF_W-1]}}, off_i};
   assign taken    = bc_i ? n_i : z_i;

   always_comb begin
      next_pc_o = pcInc;
      if (pl_i) begin
         if (jb_i)
            next_pc_o = reg_a_i;
         else if (taken)
            next_pc_o = pcBranch;
      end
   end

endmodule

// File: rtl/program_sequencer.sv
// Instruction fetch/sequencing front end: fetches over a req/ack handshake,
// presents each instruction for one EXEC cycle, then resolves the next PC.
module program_sequencer
   import seq_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter int              IR_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            en,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [IR_W-1:0] imem_rdata,
   output logic [IR_W-1:0] IR,
   output logic            ir_valid,
   input  logic [PC_W-1:0] reg_a,
   input  logic            Z,
   input  logic            N,
   output logic [PC_W-1:0] pc
);

   seqState_t       state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [IR_W-1:0] ir_q, ir_d;
   logic [PC_W-1:0] pcNext;
   logic            pl, jb, bc;
   logic [OFF_W-1:0] off;

   assign pl  = ir_q[PL_BIT_A] & ir_q[PL_BIT_B];
   assign jb  = ir_q[JB_BIT];
   assign bc  = ir_q[BC_BIT];
   assign off = {ir_q[OFF_HI_MSB:OFF_HI_LSB], ir_q[OFF_LO_MSB:OFF_LO_LSB]};

   next_pc #(.PC_W(PC_W)) uNextPc (
      .pc_i      (pc_q),
      .pl_i      (pl),
      .jb_i      (jb),
      .bc_i      (bc),
      .off_i     (off),
      .reg_a_i   (reg_a),
      .z_i       (Z),
      .n_i       (N),
      .next_pc_o (pcNext)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= IR_W'(NOP_IR);
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // en only matters at IDLE and at the end of EXEC, so a fetch already in
   // flight always completes and its instruction executes exactly once
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      unique case (state_q)
         IDLE: begin
            if (en)
               state_d = FETCH;
         end
         FETCH: begin
            if (imem_ack) begin
               ir_d    = imem_rdata;
               state_d = EXEC;
            end
         end
         EXEC: begin
            pc_d    = pcNext;
            state_d = en ? FETCH : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode straight from the state register so reset drops req at once
   assign imem_req  = (state_q == FETCH);
   assign imem_addr = (state_q == FETCH) ? pc_q : '0;
   assign ir_valid  = (state_q == EXEC);
   assign IR        = (state_q == EXEC) ? ir_q : IR_W'(NOP_IR);
   assign pc        = pc_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: acts as instruction memory and datapath
// flag source, checking fetch addresses, IR presentation and next-PC resolution.
module tb_program_sequencer;
   import seq_pkg::*;

   logic        CLK;
   logic        RST_N;
   logic        en;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic [15:0] IR;
   logic        ir_valid;
   logic [7:0]  reg_a;
   logic        Z;
   logic        N;
   logic [7:0]  pc;

   int compareCount;
   int mismatchCount;

   localparam logic [15:0] I_ALU   = 16'h0000;
   localparam logic [15:0] I_JMP   = 16'hE000;
   localparam logic [15:0] I_BZ_M2 = 16'hC1C6;
   localparam logic [15:0] I_BN_P5 = 16'hC205;
   localparam logic [15:0] I_BZ_P5 = 16'hC005;

   program_sequencer dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .en         (en),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .IR         (IR),
      .ir_valid   (ir_valid),
      .reg_a      (reg_a),
      .Z          (Z),
      .N          (N),
      .pc         (pc)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Serve one fetch at expAddr after waitN stall cycles, then check the EXEC
   // cycle and the resolved PC one cycle later
   task automatic applyStimulus(input string tag, input logic [7:0] expAddr,
                                input logic [15:0] instr, input int waitN,
                                input logic [7:0] regA, input logic z, input logic n,
                                input logic [7:0] expPc);
      int budget;
      budget = 0;
      while (!imem_req && budget < 10) begin
         @(negedge CLK);
         budget++;
      end
      checkOutput({tag, " req"}, 32'(imem_req), 32'd1);
      checkOutput({tag, " addr"}, 32'(imem_addr), 32'(expAddr));
      for (int w = 0; w < waitN; w++) begin
         @(negedge CLK);
         checkOutput({tag, " wait req"}, 32'(imem_req), 32'd1);
         checkOutput({tag, " wait addr"}, 32'(imem_addr), 32'(expAddr));
         checkOutput({tag, " wait valid"}, 32'(ir_valid), 32'd0);
      end
      imem_ack   = 1'b1;
      imem_rdata = instr;
      @(negedge CLK);
      imem_ack   = 1'b0;
      imem_rdata = 16'(($urandom));
      reg_a      = regA;
      Z          = z;
      N          = n;
      checkOutput({tag, " exec valid"}, 32'(ir_valid), 32'd1);
      checkOutput({tag, " exec IR"}, 32'(IR), 32'(instr));
      @(negedge CLK);
      Z = 1'b0;
      N = 1'b0;
      checkOutput({tag, " after valid"}, 32'(ir_valid), 32'd0);
      checkOutput({tag, " after IR"}, 32'(IR), 32'hC000);
      checkOutput({tag, " next pc"}, 32'(pc), 32'(expPc));
   endtask

   initial begin
      compareCount  = 0;
      mismatchCount = 0;
      RST_N      = 1'b0;
      en         = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = 16'h0;
      reg_a      = 8'h00;
      Z          = 1'b0;
      N          = 1'b0;

      @(negedge CLK);
      checkOutput("reset req", 32'(imem_req), 32'd0);
      checkOutput("reset addr", 32'(imem_addr), 32'd0);
      checkOutput("reset valid", 32'(ir_valid), 32'd0);
      checkOutput("reset IR", 32'(IR), 32'hC000);
      checkOutput("reset pc", 32'(pc), 32'd0);
      RST_N = 1'b1;
      en    = 1'b1;

      applyStimulus("seq0", 8'h00, I_ALU, 0, 8'h00, 1'b0, 1'b0, 8'h01);
      applyStimulus("seq1", 8'h01, I_ALU, 0, 8'h00, 1'b0, 1'b0, 8'h02);
      applyStimulus("wait3", 8'h02, I_ALU, 3, 8'h00, 1'b0, 1'b0, 8'h03);
      applyStimulus("jmp10", 8'h03, I_JMP, 0, 8'h10, 1'b0, 1'b0, 8'h10);
      applyStimulus("bz taken", 8'h10, I_BZ_M2, 0, 8'h00, 1'b1, 1'b0, 8'h0E);
      applyStimulus("jmp10b", 8'h0E, I_JMP, 0, 8'h10, 1'b0, 1'b0, 8'h10);
      applyStimulus("bz not", 8'h10, I_BZ_M2, 0, 8'h00, 1'b0, 1'b1, 8'h11);
      applyStimulus("jmp20", 8'h11, I_JMP, 0, 8'h20, 1'b0, 1'b0, 8'h20);
      applyStimulus("bn taken", 8'h20, I_BN_P5, 1, 8'h00, 1'b0, 1'b1, 8'h25);
      applyStimulus("jmp80", 8'h25, I_JMP, 0, 8'h80, 1'b0, 1'b0, 8'h80);
      applyStimulus("jmpFF", 8'h80, I_JMP, 0, 8'hFF, 1'b0, 1'b0, 8'hFF);
      applyStimulus("wrap FF", 8'hFF, I_ALU, 0, 8'h00, 1'b1, 1'b1, 8'h00);
      applyStimulus("jmpFE", 8'h00, I_JMP, 0, 8'hFE, 1'b0, 1'b0, 8'hFE);
      applyStimulus("wrap br", 8'hFE, I_BZ_P5, 0, 8'h00, 1'b1, 1'b0, 8'h03);

      // Reset in the middle of a stalled fetch, with a late ack afterwards
      @(negedge CLK);
      checkOutput("midfetch req", 32'(imem_req), 32'd1);
      checkOutput("midfetch addr", 32'(imem_addr), 32'h03);
      RST_N = 1'b0;
      en    = 1'b0;
      #1;
      checkOutput("async req drop", 32'(imem_req), 32'd0);
      checkOutput("async pc", 32'(pc), 32'd0);
      @(negedge CLK);
      RST_N      = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = I_JMP;
      @(negedge CLK);
      @(negedge CLK);
      checkOutput("stray ack valid", 32'(ir_valid), 32'd0);
      checkOutput("stray ack req", 32'(imem_req), 32'd0);
      checkOutput("stray ack pc", 32'(pc), 32'd0);
      imem_ack = 1'b0;

      // en drops while the fetch is outstanding: one execute, then park
      en = 1'b1;
      @(negedge CLK);
      en = 1'b0;
      applyStimulus("en drop", 8'h00, I_ALU, 1, 8'h00, 1'b0, 1'b0, 8'h01);
      checkOutput("parked req", 32'(imem_req), 32'd0);
      @(negedge CLK);
      checkOutput("parked valid", 32'(ir_valid), 32'd0);
      checkOutput("parked req2", 32'(imem_req), 32'd0);
      checkOutput("parked pc", 32'(pc), 32'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
